// File: rtl/fir_out_decimator.sv
// fir_out_decimator: sink-side companion of the 9-tap FIR low-pass filter.
// Drops the filter warm-up samples, keeps 1 of every DEC_FACTOR accepted samples,
// rescales the 17-bit stream to 8 bits with round-half-up, and queues results in a
// small FIFO behind a valid/ready output.
// Optional build macro: FIR_OUT_DEC_SAT_EN -- saturate instead of wrapping when the
// rescaled value does not fit in OUT_W bits.
module fir_out_decimator #(
    parameter int IN_W       = 17,
    parameter int OUT_W      = 8,
    parameter int SHIFT      = 9,
    parameter int DEC_FACTOR = 4,
    parameter int WARMUP     = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RSTn,
    input  logic                          IN_VALID,
    input  logic [IN_W-1:0]               IN_DATA,
    output logic [OUT_W-1:0]              OUT_DATA,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          OVERFLOW,
    output logic                          WARM
);

    localparam int WC_W  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int PH_W  = (DEC_FACTOR > 1) ? $clog2(DEC_FACTOR) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [IN_W:0]      ROUND_K   = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [WC_W-1:0]    WC_LAST   = WC_W'(WARMUP - 1);
    localparam logic [PH_W-1:0]    PH_LAST   = PH_W'(DEC_FACTOR - 1);
    localparam logic [LVL_W-1:0]   LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]   LVL_ZERO  = {LVL_W{1'b0}};

    logic [WC_W-1:0]   r_warm_cnt;
    logic              r_warm;
    logic [PH_W-1:0]   r_phase;
    logic              r_s1_valid;
    logic [OUT_W-1:0]  r_s1_data;
    logic [OUT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [OUT_W-1:0]  r_out_data;
    logic              r_out_valid;
    logic              r_overflow;

    logic [IN_W:0]     w_sum;
    logic [OUT_W-1:0]  w_scaled;
    logic              w_keep;
    logic              w_pop;
    logic              w_push;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;
    logic [LVL_W-1:0]  w_level_nxt;
    logic [OUT_W-1:0]  w_out_nxt;

    // Round-half-up rescale at IN_W+1 bits so the rounding constant cannot wrap.
    assign w_sum = {1'b0, IN_DATA} + ROUND_K;

`ifdef FIR_OUT_DEC_SAT_EN
    logic [IN_W:0]     w_shifted;
    assign w_shifted = w_sum >> SHIFT;
    assign w_scaled  = (w_shifted > {{(IN_W-OUT_W+1){1'b0}}, {OUT_W{1'b1}}}) ?
                       {OUT_W{1'b1}} : w_shifted[OUT_W-1:0];
`else
    assign w_scaled  = OUT_W'(w_sum >> SHIFT);
`endif

    // A sample is kept when it is accepted after warm-up at decimation phase 0.
    assign w_keep = IN_VALID && r_warm && (r_phase == {PH_W{1'b0}});

    // Warm-up drop counter; WARM rises after the last discarded sample.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_warm_cnt <= {WC_W{1'b0}};
            r_warm     <= (WARMUP == 0);
        end else if (IN_VALID && !r_warm) begin
            r_warm_cnt <= r_warm_cnt + WC_W'(1'b1);
            r_warm     <= (r_warm_cnt == WC_LAST);
        end else begin
            r_warm_cnt <= r_warm_cnt;
            r_warm     <= r_warm;
        end
    end

    // Decimation phase, advanced only by accepted post-warm-up samples.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_phase <= {PH_W{1'b0}};
        end else if (IN_VALID && r_warm) begin
            r_phase <= (r_phase == PH_LAST) ? {PH_W{1'b0}} : (r_phase + PH_W'(1'b1));
        end else begin
            r_phase <= r_phase;
        end
    end

    // Stage 1: registered scaled value of the kept sample, pushed on the next edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= {OUT_W{1'b0}};
        end else begin
            r_s1_valid <= w_keep;
            r_s1_data  <= w_keep ? w_scaled : r_s1_data;
        end
    end

    // FIFO control: pop on handshake; a push into a full FIFO needs a same-edge pop.
    always_comb begin
        w_pop        = (r_level != LVL_ZERO) && OUT_READY;
        w_push       = r_s1_valid && ((r_level != LVL_FULL) || w_pop);
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_W'(1'b1);
            2'b01:   w_level_nxt = r_level - LVL_W'(1'b1);
            default: w_level_nxt = r_level;
        endcase
        if (w_level_nxt == LVL_ZERO) begin
            w_out_nxt = r_out_data;
        end else if (w_push && (r_level == LVL_W'(w_pop))) begin
            w_out_nxt = r_s1_data;
        end else begin
            w_out_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    // FIFO storage, pointers, level, registered head and sticky overflow.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {OUT_W{1'b0}};
            end
            r_wr_ptr    <= {PTR_W{1'b0}};
            r_rd_ptr    <= {PTR_W{1'b0}};
            r_level     <= LVL_ZERO;
            r_out_data  <= {OUT_W{1'b0}};
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_s1_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1'b1);
            end else begin
                r_wr_ptr        <= r_wr_ptr;
            end
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_level     <= w_level_nxt;
            r_out_data  <= w_out_nxt;
            r_out_valid <= (w_level_nxt != LVL_ZERO);
            r_overflow  <= r_overflow || (r_s1_valid && !w_push);
        end
    end

    assign OUT_DATA   = r_out_data;
    assign OUT_VALID  = r_out_valid;
    assign FIFO_LEVEL = r_level;
    assign OVERFLOW   = r_overflow;
    assign WARM       = r_warm;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed testbench for fir_out_decimator with default parameters.
module tb_fir_out_decimator;

`ifdef FIR_OUT_DEC_SAT_EN
    localparam logic [7:0] EXP_TOP = 8'd255;
`else
    localparam logic [7:0] EXP_TOP = 8'd0;
`endif

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [16:0] IN_DATA = 17'd0;
    logic [7:0]  OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [2:0]  FIFO_LEVEL;
    logic        OVERFLOW;
    logic        WARM;

    int n_tests = 0;
    int n_fail  = 0;

    fir_out_decimator dut (
        .CLK(CLK), .RSTn(RSTn), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .FIFO_LEVEL(FIFO_LEVEL), .OVERFLOW(OVERFLOW), .WARM(WARM)
    );

    always #5 CLK = ~CLK;

    task automatic step(input logic v, input logic [16:0] d);
        IN_VALID = v;
        IN_DATA  = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        RSTn      = 1'b0;
        @(posedge CLK);
        #1;
        RSTn      = 1'b1;
    endtask

    task automatic warm_up();
        for (int i = 0; i < 11; i++) step(1'b1, 17'd0);
    endtask

    // one kept sample followed by three decimated-away fillers
    task automatic keep_sample(input logic [16:0] d);
        step(1'b1, d);
        for (int i = 0; i < 3; i++) step(1'b1, 17'd0);
    endtask

    task automatic test_reset();
        IN_VALID = 1'b0; OUT_READY = 1'b0; RSTn = 1'b0;
        #3;
        n_tests++;
        if (OUT_DATA !== 8'd0 || OUT_VALID !== 1'b0 || FIFO_LEVEL !== 3'd0 ||
            OVERFLOW !== 1'b0 || WARM !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: data=%0d valid=%b level=%0d ovf=%b warm=%b, required 0 0 0 0 0",
                     OUT_DATA, OUT_VALID, FIFO_LEVEL, OVERFLOW, WARM);
        end
        @(posedge CLK); #1;
        RSTn = 1'b1;
    endtask

    task automatic test_warmup_constant();
        OUT_READY = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step(1'b1, 17'd25856);
            n_tests++;
            if (WARM !== (i == 11) || OUT_VALID !== 1'b0) begin
                n_fail++;
                $display("FAIL warmup_%0d: warm=%b valid=%b, required warm=%b valid=0",
                         i, WARM, OUT_VALID, (i == 11));
            end
        end
        step(1'b1, 17'd25856);   // kept
        n_tests++;
        if (OUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: valid=%b, required 0", OUT_VALID);
        end
        step(1'b1, 17'd25856);
        n_tests++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'd51 || FIFO_LEVEL !== 3'd1) begin
            n_fail++;
            $display("FAIL first_output: valid=%b data=%0d level=%0d, required 1 51 1",
                     OUT_VALID, OUT_DATA, FIFO_LEVEL);
        end
        step(1'b1, 17'd25856);
        n_tests++;
        if (OUT_VALID !== 1'b0 || OUT_DATA !== 8'd51 || FIFO_LEVEL !== 3'd0) begin
            n_fail++;
            $display("FAIL empty_hold: valid=%b data=%0d level=%0d, required 0 51 0",
                     OUT_VALID, OUT_DATA, FIFO_LEVEL);
        end
        step(1'b1, 17'd25856);
        step(1'b1, 17'd25856);   // kept
        step(1'b1, 17'd25856);
        n_tests++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'd51) begin
            n_fail++;
            $display("FAIL second_output: valid=%b data=%0d, required 1 51", OUT_VALID, OUT_DATA);
        end
    endtask

    task automatic test_ramp_with_stalls();
        logic [7:0] got[$];
        logic [7:0] exp_v [4];
        exp_v[0] = 8'd0; exp_v[1] = 8'd4; exp_v[2] = 8'd8; exp_v[3] = 8'd12;
        do_reset();
        warm_up();
        OUT_READY = 1'b1;
        for (int n = 0; n < 16; n++) begin
            step(1'b1, 17'(n * 512));
            if (OUT_VALID) got.push_back(OUT_DATA);
            if (n % 3 == 0) begin
                step(1'b0, 17'h1FFFF);
                if (OUT_VALID) got.push_back(OUT_DATA);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 17'd0);
            if (OUT_VALID) got.push_back(OUT_DATA);
        end
        n_tests++;
        if (got.size() !== 4) begin
            n_fail++;
            $display("FAIL ramp_count: got %0d outputs, required 4", got.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= got.size() || got[i] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL ramp_%0d: got %0d, required %0d", i,
                         (i < got.size()) ? got[i] : 8'hxx, exp_v[i]);
            end
        end
    endtask

    task automatic test_scaling_bounds();
        logic [7:0] exp_v [4];
        exp_v[0] = 8'd0; exp_v[1] = 8'd1; exp_v[2] = 8'd255; exp_v[3] = EXP_TOP;
        do_reset();
        warm_up();
        keep_sample(17'd255);
        keep_sample(17'd256);
        keep_sample(17'h1FEFF);
        keep_sample(17'h1FFFF);
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_v[i]) begin
                n_fail++;
                $display("FAIL scale_%0d: valid=%b data=%0d, required 1 %0d",
                         i, OUT_VALID, OUT_DATA, exp_v[i]);
            end
            step(1'b0, 17'd0);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_v [4];
        exp_v[0] = 8'd10; exp_v[1] = 8'd20; exp_v[2] = 8'd30; exp_v[3] = 8'd40;
        do_reset();
        warm_up();
        for (int i = 0; i < 4; i++) keep_sample(17'((i + 1) * 10 * 512));
        n_tests++;
        if (FIFO_LEVEL !== 3'd4 || OVERFLOW !== 1'b0 || OUT_DATA !== 8'd10) begin
            n_fail++;
            $display("FAIL full_no_ovf: level=%0d ovf=%b data=%0d, required 4 0 10",
                     FIFO_LEVEL, OVERFLOW, OUT_DATA);
        end
        keep_sample(17'(50 * 512));
        n_tests++;
        if (FIFO_LEVEL !== 3'd4 || OVERFLOW !== 1'b1 || OUT_DATA !== 8'd10) begin
            n_fail++;
            $display("FAIL overflow_set: level=%0d ovf=%b data=%0d, required 4 1 10",
                     FIFO_LEVEL, OVERFLOW, OUT_DATA);
        end
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_v[i]) begin
                n_fail++;
                $display("FAIL drain_%0d: valid=%b data=%0d, required 1 %0d",
                         i, OUT_VALID, OUT_DATA, exp_v[i]);
            end
            step(1'b0, 17'd0);
        end
        n_tests++;
        if (FIFO_LEVEL !== 3'd0 || OUT_VALID !== 1'b0 || OVERFLOW !== 1'b1) begin
            n_fail++;
            $display("FAIL drained: level=%0d valid=%b ovf=%b, required 0 0 1",
                     FIFO_LEVEL, OUT_VALID, OVERFLOW);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_v [4];
        exp_v[0] = 8'd2; exp_v[1] = 8'd3; exp_v[2] = 8'd4; exp_v[3] = 8'd5;
        do_reset();
        warm_up();
        for (int i = 1; i <= 4; i++) keep_sample(17'(i * 512));
        step(1'b1, 17'(5 * 512));    // kept into stage 1
        OUT_READY = 1'b1;
        step(1'b1, 17'd0);           // push and pop on the same edge while full
        OUT_READY = 1'b0;
        n_tests++;
        if (FIFO_LEVEL !== 3'd4 || OVERFLOW !== 1'b0 || OUT_DATA !== 8'd2) begin
            n_fail++;
            $display("FAIL full_push_pop: level=%0d ovf=%b data=%0d, required 4 0 2",
                     FIFO_LEVEL, OVERFLOW, OUT_DATA);
        end
        step(1'b1, 17'd0);
        step(1'b1, 17'd0);
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_v[i]) begin
                n_fail++;
                $display("FAIL b2b_%0d: valid=%b data=%0d, required 1 %0d",
                         i, OUT_VALID, OUT_DATA, exp_v[i]);
            end
            step(1'b0, 17'd0);
        end
        n_tests++;
        if (OVERFLOW !== 1'b0 || FIFO_LEVEL !== 3'd0) begin
            n_fail++;
            $display("FAIL b2b_end: ovf=%b level=%0d, required 0 0", OVERFLOW, FIFO_LEVEL);
        end
    endtask

    task automatic test_midop_reset();
        do_reset();
        warm_up();
        for (int i = 1; i <= 3; i++) keep_sample(17'(i * 512));
        n_tests++;
        if (FIFO_LEVEL !== 3'd3 || WARM !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: level=%0d warm=%b, required 3 1", FIFO_LEVEL, WARM);
        end
        #2;
        RSTn = 1'b0;
        #1;
        n_tests++;
        if (OUT_VALID !== 1'b0 || FIFO_LEVEL !== 3'd0 || OVERFLOW !== 1'b0 || WARM !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b level=%0d ovf=%b warm=%b, required 0 0 0 0",
                     OUT_VALID, FIFO_LEVEL, OVERFLOW, WARM);
        end
        @(posedge CLK); #1;
        RSTn = 1'b1;
        OUT_READY = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step(1'b1, 17'd25856);
            n_tests++;
            if (WARM !== (i == 11) || OUT_VALID !== 1'b0) begin
                n_fail++;
                $display("FAIL rewarm_%0d: warm=%b valid=%b, required warm=%b valid=0",
                         i, WARM, OUT_VALID, (i == 11));
            end
        end
        step(1'b1, 17'd25856);
        step(1'b1, 17'd25856);
        n_tests++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'd51) begin
            n_fail++;
            $display("FAIL rewarm_output: valid=%b data=%0d, required 1 51", OUT_VALID, OUT_DATA);
        end
    endtask

    initial begin
        test_reset();
        test_warmup_constant();
        test_ramp_with_stalls();
        test_scaling_bounds();
        test_overflow();
        test_back_to_back();
        test_midop_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
